// File: rtl/ra_wb.sv
// Register-file write-back buffer: a 2-entry result FIFO feeding a registered write port.
// Also reports pending-write bits and forwards the youngest queued value for hazard handling.
module ra_wb #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_ad,
    input  logic [DW-1:0]         in_d,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  we,
    output logic [AW-1:0]         wad,
    output logic [DW-1:0]         wd,
    output logic [(1<<AW)-1:0]    pend,
    input  logic [AW-1:0]         fwd_ad,
    output logic                  fwd_hit,
    output logic [DW-1:0]         fwd_d
);

    localparam int NREG = 1 << AW;

    // Slot 0 is always the FIFO head; slot 1 is only meaningful when two entries are queued.
    logic [1:0]    r_count;
    logic [AW-1:0] r_fifo_ad [2];
    logic [DW-1:0] r_fifo_d  [2];
    logic          r_we;
    logic [AW-1:0] r_wad;
    logic [DW-1:0] r_wd;

    logic w_hs;
    logic w_pop;
    logic w_direct;
    logic w_push;
    logic w_tail_idx;

    assign in_ready   = (r_count != 2'd2) && !rst;
    assign w_hs       = in_valid && in_ready;
    assign w_pop      = !hold && (r_count != 2'd0);
    assign w_direct   = !hold && (r_count == 2'd0) && w_hs;
    assign w_push     = w_hs && !w_direct && !flush;
    assign w_tail_idx = (r_count == 2'd1) && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_we    <= 1'b0;
            r_wad   <= '0;
            r_wd    <= '0;
        end else if (flush) begin
            // The write already on the port completes; wad/wd simply keep their values.
            r_count <= 2'd0;
            r_we    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_we  <= 1'b1;
                r_wad <= r_fifo_ad[0];
                r_wd  <= r_fifo_d[0];
            end else if (w_direct) begin
                r_we  <= 1'b1;
                r_wad <= in_ad;
                r_wd  <= in_d;
            end else begin
                r_we  <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO payload registers are deliberately not reset; r_count alone decides validity.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_fifo_ad[0] <= r_fifo_ad[1];
            r_fifo_d[0]  <= r_fifo_d[1];
        end
        // NOTE: non-blocking updates let a push into slot 0 override the shift above (last write wins).
        if (w_push) begin
            r_fifo_ad[w_tail_idx] <= in_ad;
            r_fifo_d[w_tail_idx]  <= in_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before any conditional, so no latch is inferred.
        pend = '0;
        for (int r = 0; r < NREG; r++) begin
            if ((r_count != 2'd0) && (r_fifo_ad[0] == AW'(r))) pend[r] = 1'b1;
            if ((r_count == 2'd2) && (r_fifo_ad[1] == AW'(r))) pend[r] = 1'b1;
            if (r_we && (r_wad == AW'(r)))                     pend[r] = 1'b1;
        end
    end

    // Youngest value wins: tail, then head, then the write currently on the port.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_d   = '0;
        if ((r_count == 2'd2) && (r_fifo_ad[1] == fwd_ad)) begin
            fwd_hit = 1'b1;
            fwd_d   = r_fifo_d[1];
        end else if ((r_count != 2'd0) && (r_fifo_ad[0] == fwd_ad)) begin
            fwd_hit = 1'b1;
            fwd_d   = r_fifo_d[0];
        end else if (r_we && (r_wad == fwd_ad)) begin
            fwd_hit = 1'b1;
            fwd_d   = r_wd;
        end
    end

    assign we  = r_we;
    assign wad = r_wad;
    assign wd  = r_wd;

endmodule

// File: tb/tb_ra_wb.sv
// Directed testbench for ra_wb (DW=16, AW=2): each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_ra_wb;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_ad;
    logic [DW-1:0] in_d;
    logic          hold;
    logic          flush;
    logic          we;
    logic [AW-1:0] wad;
    logic [DW-1:0] wd;
    logic [3:0]    pend;
    logic [AW-1:0] fwd_ad;
    logic          fwd_hit;
    logic [DW-1:0] fwd_d;

    int n_tests;
    int n_fail;
    logic [31:0] got;
    logic [31:0] expv;

    ra_wb #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ad    (in_ad),
        .in_d     (in_d),
        .hold     (hold),
        .flush    (flush),
        .we       (we),
        .wad      (wad),
        .wd       (wd),
        .pend     (pend),
        .fwd_ad   (fwd_ad),
        .fwd_hit  (fwd_hit),
        .fwd_d    (fwd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then sit 1 ns past it so registered outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_ad = '0; in_d = '0;
        hold = 1'b0; flush = 1'b0; fwd_ad = '0;
        step(); step();
        got  = 32'({we, wad, wd, pend, fwd_hit, in_ready});
        expv = 32'(0);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, expv);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        step();
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_ad = 2'd2; in_d = 16'h0007; fwd_ad = 2'd2;
        #1;
        got  = 32'({in_ready, fwd_hit});
        expv = 32'({1'b1, 1'b0});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL single_offer_ready_nofwd: got %h expected %h", got, expv);
        end
        step();
        in_valid = 1'b0;
        #1;
        got  = 32'({we, wad, wd, pend});
        expv = 32'({1'b1, 2'd2, 16'h0007, 4'b0100});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL single_write_port: got %h expected %h", got, expv);
        end
        got  = 32'({fwd_hit, fwd_d});
        expv = 32'({1'b1, 16'h0007});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL single_fwd_outstage: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({we, pend});
        expv = 32'({1'b0, 4'b0000});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL single_write_done: got %h expected %h", got, expv);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ad = 2'(i);
            in_d  = 16'(16'h0100 + i);
            step();
            got  = 32'({we, wad, wd});
            expv = 32'({1'b1, 2'(i), 16'(16'h0100 + i)});
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL b2b_write_%0d: got %h expected %h", i, got, expv);
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got we=%b expected 0", we);
        end
    endtask

    task automatic test_hold();
        hold = 1'b1; in_valid = 1'b1; in_ad = 2'd1; in_d = 16'h000A;
        step();
        in_ad = 2'd2; in_d = 16'h000B;
        step();
        in_ad = 2'd3; in_d = 16'h000C;
        #1;
        got  = 32'({in_ready, pend, we});
        expv = 32'({1'b0, 4'b0110, 1'b0});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_full: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({in_ready, pend, we});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_retain: got %h expected %h", got, expv);
        end
        hold = 1'b0;
        step();
        got  = 32'({we, wad, wd, pend, in_ready});
        expv = 32'({1'b1, 2'd1, 16'h000A, 4'b0110, 1'b1});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_drain_1: got %h expected %h", got, expv);
        end
        step();
        in_valid = 1'b0;
        #1;
        got  = 32'({we, wad, wd, pend});
        expv = 32'({1'b1, 2'd2, 16'h000B, 4'b1100});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_drain_2: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({we, wad, wd});
        expv = 32'({1'b1, 2'd3, 16'h000C});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_drain_3: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({we, pend});
        expv = 32'(0);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL hold_drain_done: got %h expected %h", got, expv);
        end
    endtask

    task automatic test_forward();
        hold = 1'b1; in_valid = 1'b1; in_ad = 2'd1; in_d = 16'h0010;
        step();
        in_d = 16'h0020;
        step();
        in_valid = 1'b0; fwd_ad = 2'd1;
        #1;
        got  = 32'({fwd_hit, fwd_d});
        expv = 32'({1'b1, 16'h0020});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL fwd_tail: got %h expected %h", got, expv);
        end
        fwd_ad = 2'd0;
        #1;
        got  = 32'({fwd_hit, fwd_d});
        expv = 32'(0);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL fwd_miss: got %h expected %h", got, expv);
        end
        fwd_ad = 2'd1; hold = 1'b0;
        step();
        got  = 32'({we, wd, fwd_hit, fwd_d});
        expv = 32'({1'b1, 16'h0010, 1'b1, 16'h0020});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL fwd_head_over_port: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({fwd_hit, fwd_d});
        expv = 32'({1'b1, 16'h0020});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL fwd_port: got %h expected %h", got, expv);
        end
        step();
        n_tests++;
        if (fwd_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_idle: got %b expected 0", fwd_hit);
        end
    endtask

    task automatic test_flush();
        int stray;
        hold = 1'b1; in_valid = 1'b1; in_ad = 2'd3; in_d = 16'h0033;
        step();
        in_ad = 2'd1; in_d = 16'h0011;
        step();
        hold = 1'b0; in_ad = 2'd2; in_d = 16'h0022;
        step();
        flush = 1'b1;
        #1;
        got  = 32'({we, wad, wd, in_ready});
        expv = 32'({1'b1, 2'd3, 16'h0033, 1'b1});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL flush_current_write: got %h expected %h", got, expv);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        got  = 32'({we, pend, in_ready, wad, wd});
        expv = 32'({1'b0, 4'b0000, 1'b1, 2'd3, 16'h0033});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL flush_cleared: got %h expected %h", got, expv);
        end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (we !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL flush_no_stray_write: got %0d writes expected 0", stray);
        end
    endtask

    task automatic test_full_pop();
        hold = 1'b1; in_valid = 1'b1; in_ad = 2'd0; in_d = 16'h0001;
        step();
        in_ad = 2'd1; in_d = 16'h0002;
        step();
        hold = 1'b0; in_ad = 2'd2; in_d = 16'h0003;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b expected 0", in_ready);
        end
        step();
        got  = 32'({we, wad, wd, pend, in_ready});
        expv = 32'({1'b1, 2'd0, 16'h0001, 4'b0011, 1'b1});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL full_pop_head: got %h expected %h", got, expv);
        end
        step();
        in_valid = 1'b0;
        #1;
        got  = 32'({we, wad, wd, pend, in_ready});
        expv = 32'({1'b1, 2'd1, 16'h0002, 4'b0110, 1'b1});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL full_push_pop: got %h expected %h", got, expv);
        end
        step();
        got  = 32'({we, wad, wd, pend});
        expv = 32'({1'b1, 2'd2, 16'h0003, 4'b0100});
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL full_last: got %h expected %h", got, expv);
        end
        step();
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle: got we=%b expected 0", we);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        hold = 1'b1; in_valid = 1'b1; in_ad = 2'd1; in_d = 16'h0005;
        step();
        in_ad = 2'd2; in_d = 16'h0006;
        step();
        hold = 1'b0; in_valid = 1'b0;
        step();
        n_tests++;
        if (we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: got we=%b expected 1", we);
        end
        rst = 1'b1; fwd_ad = 2'd2;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready_low: got %b expected 0", in_ready);
        end
        step();
        got  = 32'({we, wad, wd, pend, fwd_hit, in_ready});
        expv = 32'(0);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL rstmid_cleared: got %h expected %h", got, expv);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_release_ready: got %b expected 1", in_ready);
        end
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (we !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rstmid_dropped: got %0d writes expected 0", stray);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_hold();
        test_forward();
        test_flush();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
